instr_fetch_q: RTL
==================

// Module: instr_fetch_q
// PURPOSE
//  Instruction fetch stage with prefetch queue, sitting directly upstream of the single-cycle datapath's
//  instruction/decode path. Issues word reads to instruction memory over a req/gnt + rvalid bus,
//  buffers {pc,instr} pairs in a small queue, and presents them to decode with a valid/ready handshake.
//  Branch/jump redirects flush the queue and discard any in-flight response.
// PARAMETERS
//  DEPTH     4             queue entries (power of two, >=2)
//  RESET_PC  32'h0000_3000 fetch address after reset
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst_n          in   1   reset, synchronous, active-high
//  redirect_i     in   1   branch/jump taken: restart fetch at redirect_pc_i
//  redirect_pc_i  in   32  new fetch address; bits [1:0] ignored (treated as 0)
//  imem_req_o     out  1   read request to instruction memory
//  imem_addr_o    out  32  word-aligned request address, stable while req && !gnt
//  imem_gnt_i     in   1   request accepted this cycle
//  imem_rvalid_i  in   1   read data valid (>=1 cycle after gnt)
//  imem_rdata_i   in   32  instruction word
//  if_valid_o     out  1   head entry valid to decode
//  if_instr_o     out  32  head instruction
//  if_pc_o        out  32  head instruction address
//  if_ready_i     in   1   decode accepts head this cycle (pop when valid && ready)
// BEHAVIOUR
//  - Reset: state IDLE, fetch_pc=RESET_PC, queue empty; imem_req_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0.
//  - At most one outstanding request. Slot reserved at grant: issue only if count+outstanding < DEPTH,
//    so a response always has space (no backpressure on rvalid).
//  - FSM IDLE: imem_req_o = (count<DEPTH) && !redirect_i; imem_addr_o=fetch_pc.
//    req&&gnt -> WAIT, fetch_pc += 4 (wraps mod 2^32).
//  - WAIT: rvalid -> push {fetch_pc-4, rdata}, -> IDLE (next request earliest following cycle).
//  - DROP: awaiting response of a cancelled request; rvalid -> data discarded, -> IDLE.
//  - redirect_i (any state, highest priority): queue flushed (count=0, pop ignored), fetch_pc=redirect_pc_i.
//    IDLE: stays IDLE, req suppressed that cycle (a gnt seen that cycle must not occur since req=0).
//    WAIT with no rvalid -> DROP. WAIT with rvalid same cycle -> data discarded, -> IDLE. DROP -> DROP.
//  - Simultaneous push and pop: both performed, count unchanged; pop from empty queue ignored.
//  - Output: if_valid_o = (count!=0); if_instr_o/if_pc_o from head, registered storage; head held stable
//    while valid && !ready. Latency gnt->... rvalid -> if_valid_o: 1 cycle (see CONFIGURATION).
//  - rvalid in IDLE (e.g. stale response after reset mid-operation) is ignored.
//  - Reset asserted mid-operation: same as power-on reset next cycle; in-flight response dropped via above rule.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: in WAIT with count==0, rvalid and no redirect, if_valid_o/if_instr_o/if_pc_o are
//    driven combinationally from imem_rdata_i/fetch_pc-4 (0-cycle latency); if if_ready_i the entry is
//    consumed and not pushed, else it is pushed.
//  FETCH_BYPASS_EN undefined: response always pushed; earliest if_valid_o one cycle after rvalid.
// STRUCTURE
//  - Shared header (fetch_defs): RESET_PC default, FSM state encodings IDLE/WAIT/DROP (2 bits),
//    entry width constant (64 = {pc,instr}).
//  - Sub-module fetch_fifo: synchronous FIFO (DEPTH x 64), push/pop/flush, count output, head data out.
//  - Top holds FSM, fetch_pc register, request and bypass logic.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after gnt, ready=1 -> pc 0x3000,0x3004,0x3008 in order, instr matches memory.
//  2 ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, req deasserted, head 0x3000 held stable;
//    release ready -> 4 pops then fetch resumes at 0x3010.
//  3 Redirect to 0x4000 while WAIT (rvalid delayed 3 cycles) -> state DROP, stale word never reaches
//    decode; next delivered pc = 0x4000.
//  4 Redirect same cycle as rvalid and push/pop with count=2 -> queue empty next cycle, next pc = redirect target.
//  5 gnt held low 5 cycles -> imem_addr_o stable at 0x3000 throughout; redirect_pc 0x4003 -> addr 0x4000.
//  6 FETCH_BYPASS_EN, empty queue, ready=1 -> if_valid_o in same cycle as rvalid; undefined -> one cycle later.

Source files
------------

// File: rtl/instr_fetch_q_pkg.sv
// Shared fetch definitions: reset PC default, fetch FSM state encoding and queue entry layout.
package instr_fetch_q_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned ENTRY_W      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_q_fifo.sv
// fetch_fifo: synchronous DEPTH x {pc,instr} queue with push/pop/flush, occupancy count and head output.
module fetch_fifo
  import instr_fetch_q_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  // Pop from empty is ignored; push into a full queue is only taken alongside a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < (AW+1)'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_q.sv
// Instruction fetch stage with prefetch queue; one outstanding imem request, redirect flushes.
// Optional FETCH_BYPASS_EN: zero-latency forwarding of a response to decode when the queue is empty.
module instr_fetch_q
  import instr_fetch_q_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        if_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic          req, push, pop, flush;
  logic          q_valid, q_has_room, bypass_hit;
  logic [CW-1:0] count;
  fetch_entry_t  head, wdata;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc_i[1:0];

  // fetch_pc already advanced at grant, so the in-flight word belongs to fetch_pc-4.
  assign wdata      = '{pc: fetch_pc - 32'd4, instr: imem_rdata_i};
  assign q_valid    = (count != '0);
  assign q_has_room = (count < CW'(DEPTH));

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (state == WAIT) && !q_valid && imem_rvalid_i && !redirect_i;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req        = 1'b0;
    push       = 1'b0;
    flush      = redirect_i;
    pop        = q_valid && if_ready_i && !redirect_i;
    case (state)
      IDLE: begin
        req = q_has_room && !redirect_i && !rst_n;
        if (req && imem_gnt_i) begin
          state_n    = WAIT;
          fetch_pc_n = fetch_pc + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_n = IDLE;
          push    = !redirect_i && !(bypass_hit && if_ready_i);
        end else if (redirect_i) begin
          state_n = DROP;
        end
      end
      DROP: begin
        // A redirect here keeps discarding, but the awaited response still closes the drop.
        if (imem_rvalid_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (redirect_i) fetch_pc_n = {redirect_pc_i[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;
  assign if_valid_o  = q_valid || bypass_hit;
  assign if_instr_o  = bypass_hit ? imem_rdata_i : (q_valid ? head.instr : '0);
  assign if_pc_o     = bypass_hit ? wdata.pc     : (q_valid ? head.pc    : '0);

endmodule
